// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - MIPS instruction-decode stage: register file, control decode, branch resolve, hazards, ID/EX latch
module stage_id_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_read,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_alu,
  output logic              stall,
  output logic              flush,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [4:0]        ex_sa,
  output logic [5:0]        ex_funct,
  output logic [8:0]        ex_ctrl,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2**REG_AW;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;

  assign opcode  = instr[31:26];
  assign rs      = REG_AW'(instr[25:21]);
  assign rt      = REG_AW'(instr[20:16]);
  assign rd      = REG_AW'(instr[15:11]);
  assign imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  // Register file; r0 is never written so it reads back as zero
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we && enable && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs_val, rt_val;

  assign rs_val   = (rs == '0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : regs[rs];
  assign rt_val   = (rt == '0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : regs[rt];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Branch comparator operands take the EX/MEM ALU result when it is newer
  logic              fwd_ok, fwd_rs, fwd_rt;
  logic [DATA_W-1:0] br_a, br_b;

  assign fwd_ok = exmem_reg_write && !exmem_mem_read && exmem_rd != '0;
  assign fwd_rs = fwd_ok && exmem_rd == rs;
  assign fwd_rt = fwd_ok && exmem_rd == rt;
  assign br_a   = fwd_rs ? exmem_alu : rs_val;
  assign br_b   = fwd_rt ? exmem_alu : rt_val;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op[1:0]}
  logic [8:0] ctrl;

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R:          ctrl = 9'b1_0_0_0_0_1_0_10;
      OP_ADDI:       ctrl = 9'b1_0_0_0_1_0_0_00;
      OP_LW:         ctrl = 9'b1_1_0_1_1_0_0_00;
      OP_SW:         ctrl = 9'b0_0_1_0_1_0_0_00;
      OP_BEQ, OP_BNE: ctrl = 9'b0_0_0_0_0_0_1_01;
      default:       ctrl = '0;
    endcase
  end

  logic [REG_AW-1:0] ex_dest;
  logic              is_br, is_j, uses_rt;
  logic              load_use, br_raw, br_ld;

  assign ex_dest = ex_ctrl[3] ? ex_rd : ex_rt;
  assign is_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign uses_rt = (opcode == OP_R) || (opcode == OP_SW) || is_br;

  assign load_use = ex_valid && ex_ctrl[7] && ex_dest != '0 &&
                    (ex_dest == rs || (ex_dest == rt && uses_rt));
  assign br_raw   = is_br && ex_valid && ex_ctrl[8] && ex_dest != '0 &&
                    (ex_dest == rs || ex_dest == rt);
  assign br_ld    = is_br && exmem_mem_read && exmem_rd != '0 &&
                    (exmem_rd == rs || exmem_rd == rt);

  assign stall = !reset && in_valid && (load_use || br_raw || br_ld);

  // A stalled branch must not redirect: its operands are not final yet
  logic br_taken, redirect;

  assign br_taken  = ((opcode == OP_BEQ) && (br_a == br_b)) ||
                     ((opcode == OP_BNE) && (br_a != br_b));
  assign redirect  = !reset && in_valid && !stall && (br_taken || is_j);
  assign pc_src    = redirect;
  assign flush     = redirect;
  assign pc_target = is_j ? {in_pc[DATA_W-1:28], instr[25:0], 2'b00}
                          : in_pc + (imm_ext << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_sa      <= '0;
      ex_funct   <= '0;
    end else if (enable) begin
      if (stall || !in_valid) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid   <= 1'b1;
        ex_ctrl    <= ctrl;
        ex_pc      <= in_pc;
        ex_rs_data <= rs_val;
        ex_rt_data <= rt_val;
        ex_imm     <= imm_ext;
        ex_rs      <= rs;
        ex_rt      <= rt;
        ex_rd      <= rd;
        ex_sa      <= instr[10:6];
        ex_funct   <= instr[5:0];
      end
    end
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - scoreboard bench for stage_id_pipe with directed and randomized stimulus
module tb_stage_id_pipe;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid;
  logic [31:0] instr, in_pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exmem_reg_write, exmem_mem_read;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu;
  logic        stall, flush, pc_src;
  logic [31:0] pc_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_sa;
  logic [5:0]  ex_funct;
  logic [8:0]  ex_ctrl;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  stage_id_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .instr(instr), .in_pc(in_pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .exmem_rd(exmem_rd), .exmem_alu(exmem_alu),
    .stall(stall), .flush(flush), .pc_src(pc_src), .pc_target(pc_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_sa(ex_sa),
    .ex_funct(ex_funct), .ex_ctrl(ex_ctrl),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  funct;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t         exp_q[$];
  ex_t         mex;
  logic [31:0] mreg [32];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Control word straight from the opcode table
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:        return 9'b1_0_0_0_0_1_0_10;
      6'h08:        return 9'b1_0_0_0_1_0_0_00;
      6'h23:        return 9'b1_1_0_1_1_0_0_00;
      6'h2B:        return 9'b0_0_1_0_1_0_0_00;
      6'h04, 6'h05: return 9'b0_0_0_0_0_0_1_01;
      default:      return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_rf(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] a);
    if (exmem_reg_write && !exmem_mem_read && exmem_rd != 5'd0 && exmem_rd == a) return exmem_alu;
    return m_rf(a);
  endfunction

  // One ID cycle: inputs already applied at the falling edge
  task automatic cycle();
    logic [5:0]  op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b, sx, tgt;
    logic        is_br, ld_use, raw, bld, st, tk, jmp;
    ex_t         nx;
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      mex = '0;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_ctrl", ex_ctrl, 0);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_ex_data", ex_rs_data | ex_rt_data | ex_imm, 0);
      chk("rst_ex_fields", {ex_rs, ex_rt, ex_rd, ex_sa, ex_funct}, 0);
    end
    op = instr[31:26];
    rs = instr[25:21];
    rt = instr[20:16];
    sx = {{16{instr[15]}}, instr[15:0]};
    a  = m_opnd(rs);
    b  = m_opnd(rt);
    is_br  = (op == 6'h04) || (op == 6'h05);
    dest   = mex.ctrl[3] ? mex.rd : mex.rt;
    ld_use = mex.valid && mex.ctrl[7] && dest != 0 &&
             (dest == rs || (dest == rt && (op == 6'h00 || op == 6'h2B || is_br)));
    raw    = is_br && mex.valid && mex.ctrl[8] && dest != 0 && (dest == rs || dest == rt);
    bld    = is_br && exmem_mem_read && exmem_rd != 0 && (exmem_rd == rs || exmem_rd == rt);
    st     = !reset && in_valid && (ld_use || raw || bld);
    tk     = !reset && in_valid && !st && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b));
    jmp    = !reset && in_valid && !st && op == 6'h02;
    chk("stall", stall, st);
    chk("pc_src", pc_src, tk || jmp);
    chk("flush", flush, tk || jmp);
    if (tk) begin
      tgt = in_pc + sx * 4;
      chk("br_target", pc_target, tgt);
    end
    if (jmp) begin
      tgt = {in_pc[31:28], instr[25:0], 2'b00};
      chk("j_target", pc_target, tgt);
    end
    tgt = (dbg_addr == 0) ? 32'd0 : mreg[dbg_addr];
    chk("dbg_data", dbg_data, tgt);
    if (!reset && !enable) begin
      chk("frozen_valid", ex_valid, mex.valid);
      chk("frozen_ctrl", ex_ctrl, mex.ctrl);
      chk("frozen_pc", ex_pc, mex.pc);
      chk("frozen_rs_data", ex_rs_data, mex.rs_data);
    end
    if (!reset && enable) begin
      nx = mex;
      if (st || !in_valid) begin
        nx.valid = 1'b0;
        nx.ctrl  = 9'd0;
      end else begin
        nx.valid   = 1'b1;
        nx.pc      = in_pc;
        nx.rs_data = m_rf(rs);
        nx.rt_data = m_rf(rt);
        nx.imm     = sx;
        nx.rs      = rs;
        nx.rt      = rt;
        nx.rd      = instr[15:11];
        nx.sa      = instr[10:6];
        nx.funct   = instr[5:0];
        nx.ctrl    = ctrl_of(op);
      end
      mex = nx;
      exp_q.push_back(nx);
      if (wb_we && wb_addr != 0) mreg[wb_addr] = wb_data;
    end
    @(negedge clk);
  endtask

  // Monitor: every enabled edge out of reset consumes one expected ID/EX record
  initial begin
    logic en_s, rst_s;
    ex_t  e;
    forever begin
      @(posedge clk);
      en_s  = enable;
      rst_s = reset;
      #2;
      if (!rst_s && en_s) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_underflow: got ex_valid=%0b want queued entry", ex_valid);
        end else begin
          e = exp_q.pop_front();
          chk("ex_valid", ex_valid, e.valid);
          chk("ex_ctrl", ex_ctrl, e.ctrl);
          if (e.valid) begin
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_rs_data", ex_rs_data, e.rs_data);
            chk("ex_rt_data", ex_rt_data, e.rt_data);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_regs", {ex_rs, ex_rt, ex_rd}, {e.rs, e.rt, e.rd});
            chk("ex_sa_funct", {ex_sa, ex_funct}, {e.sa, e.funct});
          end
        end
      end
    end
  end

  task automatic clr();
    reset = 0; enable = 1; in_valid = 0; instr = 32'd0; in_pc = 32'd0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    exmem_reg_write = 0; exmem_mem_read = 0; exmem_rd = 0; exmem_alu = 0;
    dbg_addr = 0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0: return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
      1: return i_type(6'h08, rs, rt, imm);
      2: return i_type(6'h23, rs, rt, imm);
      3: return i_type(6'h2B, rs, rt, imm);
      4: return i_type(6'h04, rs, rt, imm);
      5: return i_type(6'h05, rs, rt, imm);
      6: return {6'h02, 26'($urandom)};
      default: return i_type(6'h0F, rs, rt, imm);
    endcase
  endfunction

  initial begin
    clr();
    reset = 1;
    mex = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    @(negedge clk);
    cycle();

    // Write-back and r0 protection
    clr(); wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
    cycle();
    clr(); wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF; dbg_addr = 5;
    #1 chk("dbg_r5", dbg_data, 32'h1234);
    cycle();
    clr(); dbg_addr = 0;
    #1 chk("dbg_r0", dbg_data, 32'd0);
    cycle();

    // Same-cycle write-back bypass into ID
    clr(); wb_we = 1; wb_addr = 3; wb_data = 32'hAA; in_valid = 1;
    instr = r_type(5'd3, 5'd3, 5'd1, 6'h20); in_pc = 32'h40;
    cycle();
    #1 chk("bypass_rs", ex_rs_data, 32'hAA);
    chk("bypass_rt", ex_rt_data, 32'hAA);

    // Load-use: one stall, one bubble, then the consumer
    clr(); in_valid = 1; instr = i_type(6'h23, 5'd1, 5'd2, 16'd0); in_pc = 32'h44;
    cycle();
    clr(); in_valid = 1; instr = r_type(5'd2, 5'd1, 5'd4, 6'h20); in_pc = 32'h48;
    #1 chk("lu_stall", stall, 1);
    cycle();
    #1 chk("lu_bubble", ex_valid, 0);
    chk("lu_released", stall, 0);
    cycle();
    #1 chk("lu_consumer", {ex_valid, ex_rd}, {1'b1, 5'd4});

    // BEQ taken, then not taken through EX/MEM forwarding
    clr(); wb_we = 1; wb_addr = 1; wb_data = 7;
    cycle();
    clr(); wb_we = 1; wb_addr = 2; wb_data = 7;
    cycle();
    clr(); in_valid = 1; instr = i_type(6'h04, 5'd1, 5'd2, 16'd3); in_pc = 32'h100;
    #1 chk("beq_taken", {pc_src, flush}, 2'b11);
    chk("beq_target", pc_target, 32'h10C);
    cycle();
    clr(); in_valid = 1; instr = i_type(6'h04, 5'd1, 5'd2, 16'd3); in_pc = 32'h100;
    exmem_reg_write = 1; exmem_rd = 2; exmem_alu = 8;
    #1 chk("beq_fwd_not_taken", pc_src, 0);
    cycle();

    // BNE depending on an ALU result still in ID/EX
    clr(); in_valid = 1; instr = i_type(6'h08, 5'd0, 5'd6, 16'd5); in_pc = 32'h1FC;
    cycle();
    clr(); in_valid = 1; instr = i_type(6'h05, 5'd6, 5'd1, 16'd2); in_pc = 32'h200;
    #1 chk("bne_raw_stall", {stall, pc_src}, 2'b10);
    cycle();
    clr(); in_valid = 1; instr = i_type(6'h05, 5'd6, 5'd1, 16'd2); in_pc = 32'h200;
    exmem_reg_write = 1; exmem_rd = 6; exmem_alu = 5;
    #1 chk("bne_resolved", {stall, pc_src}, 2'b01);
    chk("bne_target", pc_target, 32'h208);
    cycle();

    // Freeze: three disabled cycles with new instructions and write-backs
    for (int k = 0; k < 3; k++) begin
      clr(); enable = 0; in_valid = 1; instr = rnd_instr(); in_pc = 32'h300 + 4 * k;
      wb_we = 1; wb_addr = 9; wb_data = 32'hDEAD;
      cycle();
    end
    clr(); dbg_addr = 9;
    #1 chk("frozen_wb_ignored", dbg_data, 32'd0);
    cycle();

    // Reset asserted while a load-use stall is active
    clr(); in_valid = 1; instr = i_type(6'h23, 5'd1, 5'd2, 16'd0); in_pc = 32'h400;
    cycle();
    clr(); in_valid = 1; instr = r_type(5'd2, 5'd1, 5'd4, 6'h20); in_pc = 32'h404;
    #1 chk("pre_reset_stall", stall, 1);
    #1 reset = 1;
    #1 chk("reset_clears", {stall, flush, pc_src, ex_valid, ex_ctrl}, 0);
    cycle();

    // Randomized traffic with small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      clr();
      reset           = ($urandom_range(0, 99) == 0);
      enable          = ($urandom_range(0, 9) != 0);
      in_valid        = ($urandom_range(0, 6) != 0);
      instr           = rnd_instr();
      in_pc           = {$urandom} & 32'hFFFF_FFFC;
      wb_we           = $urandom_range(0, 1) == 1;
      wb_addr         = 5'($urandom_range(0, 7));
      wb_data         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      exmem_reg_write = $urandom_range(0, 1) == 1;
      exmem_mem_read  = ($urandom_range(0, 3) == 0);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_alu       = 32'($urandom_range(0, 3));
      dbg_addr        = 5'($urandom_range(0, 7));
      cycle();
    end

    clr();
    cycle();
    cycle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
